// File: rtl/blink_meter.sv
// blink_meter: measures high/low phase lengths of an asynchronous toggling line
// and flags a stalled line when no transition arrives within TIMEOUT cycles.
module blink_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_in,
  output logic [CNT_W-1:0] half_period,
  output logic             level,
  output logic             meas_valid,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    STALLED    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t state_q, state_d;

  logic             s1_q, s2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             lvl_q, lvl_d;
  logic             mv_q, mv_d;
  logic             st_q, st_d;
  logic [15:0]      ec_q, ec_d;

  logic edge_det;
  logic timeout;

  assign edge_det = s2_q ^ prev_q;
  assign timeout  = (cnt_q == TO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= led_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // The edge cycle is cycle 1 of the new phase.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_det)
      cnt_d = CNT_W'(1);
    else if (cnt_q < TO)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_FIRST: begin
        if (edge_det)
          state_d = MEASURE;
        else if (timeout)
          state_d = STALLED;
      end
      MEASURE: begin
        if (!edge_det && timeout)
          state_d = STALLED;
      end
      STALLED: begin
        if (edge_det)
          state_d = MEASURE;
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_comb begin
    hp_d  = hp_q;
    lvl_d = lvl_q;
    mv_d  = 1'b0;
    ec_d  = ec_q;
    st_d  = (state_d == STALLED);
    if (state_q == MEASURE && edge_det) begin
      hp_d  = cnt_q;
      lvl_d = prev_q;
      mv_d  = 1'b1;
      if (ec_q != 16'hFFFF)
        ec_d = ec_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_q  <= '0;
      lvl_q <= 1'b0;
      mv_q  <= 1'b0;
      st_q  <= 1'b0;
      ec_q  <= '0;
    end else begin
      hp_q  <= hp_d;
      lvl_q <= lvl_d;
      mv_q  <= mv_d;
      st_q  <= st_d;
      ec_q  <= ec_d;
    end
  end

  assign half_period = hp_q;
  assign level       = lvl_q;
  assign meas_valid  = mv_q;
  assign stalled     = st_q;
  assign edge_count  = ec_q;

endmodule

// File: tb/tb_blink_meter.sv
// tb_blink_meter: random and directed phases against a run-length model
// of the sampled line; model results appear two clocks after each sample.
module tb_blink_meter;

  localparam int CNT_W = 32;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             led_in = 1'b0;
  logic [CNT_W-1:0] half_period;
  logic             level;
  logic             meas_valid;
  logic             stalled;
  logic [15:0]      edge_count;

  blink_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .half_period(half_period),
    .level      (level),
    .meas_valid (meas_valid),
    .stalled    (stalled),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hp;
    logic        lvl;
    logic        mv;
    logic        st;
    logic [15:0] ec;
  } snap_t;

  snap_t q[$];
  snap_t e;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic m_cur;
  int   m_run;
  bit   m_ok;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Initial run length 2 accounts for the counter running from reset
  // while the first sample is still in the synchroniser.
  function automatic void m_reset();
    m_cur = 1'b0;
    m_run = 2;
    m_ok  = 1'b0;
    e     = '0;
    q.delete();
    q.push_back(e);
    q.push_back(e);
  endfunction

  // A run is measurable only if it began with a transition and never hit
  // the timeout; a run reaching TO samples with no change stalls the line.
  function automatic void m_step(input logic x);
    e.mv = 1'b0;
    if (x != m_cur) begin
      if (m_ok) begin
        e.mv  = 1'b1;
        e.hp  = 32'(m_run);
        e.lvl = m_cur;
        if (e.ec != 16'hFFFF) e.ec = e.ec + 16'd1;
      end
      m_ok  = 1'b1;
      e.st  = 1'b0;
      m_run = 1;
      m_cur = x;
    end else if (m_run == TO) begin
      e.st = 1'b1;
      m_ok = 1'b0;
    end else begin
      m_run++;
    end
    q.push_back(e);
  endfunction

  always @(posedge clk) begin : mon
    snap_t g;
    if (!rst) begin
      m_step(led_in);
      #1;
      g = q.pop_front();
      check("half_period", half_period, g.hp);
      check("level", {31'd0, level}, {31'd0, g.lvl});
      check("meas_valid", {31'd0, meas_valid}, {31'd0, g.mv});
      check("stalled", {31'd0, stalled}, {31'd0, g.st});
      check("edge_count", {16'd0, edge_count}, {16'd0, g.ec});
    end
  end

  task automatic phase(input logic v, input int n);
    led_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_hp"}, half_period, 32'd0);
    check({tag, "_lvl"}, {31'd0, level}, 32'd0);
    check({tag, "_mv"}, {31'd0, meas_valid}, 32'd0);
    check({tag, "_st"}, {31'd0, stalled}, 32'd0);
    check({tag, "_ec"}, {16'd0, edge_count}, 32'd0);
  endtask

  task automatic async_rst();
    @(posedge clk);
    #3;
    led_in = ~led_in;
    rst = 1'b1;
    #1;
    chk_zero("arst");
    m_reset();
    @(negedge clk);
    led_in = 1'b0;
    @(negedge clk);
    led_in = 1'b1;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    phase(1'b0, 4);
    for (int i = 0; i < 6; i++) phase(i % 2 == 0, 10);
    for (int i = 0; i < 6; i++) phase(i % 2 == 0, (i % 2 == 0) ? 3 : 7);

    phase(1'b0, 100);
    check("stall_hold", {31'd0, stalled}, 32'd1);
    phase(1'b1, 5);
    phase(1'b0, 5);
    phase(1'b1, 64);
    phase(1'b0, 65);
    phase(1'b1, 10);

    repeat (150) phase(~led_in, $urandom_range(1, 80));

    led_in = 1'b1;
    phase(1'b1, 3);
    async_rst();
    phase(1'b1, 6);
    repeat (30) phase(~led_in, $urandom_range(1, 20));

    repeat (65540) phase(~led_in, 1);
    repeat (10) phase(~led_in, 2);
    check("ec_sat", {16'd0, edge_count}, 32'h0000FFFF);
    check("hp_after_sat", half_period, 32'd2);
    phase(led_in, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
